// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with built-in test patterns; outputs registered 1 clk after the counters, free-running (no backpressure).
// Optional macro VGA_BORDER_EN forces an all-ones border on the first/last active row and column.
module vga_timing_pattern_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int COLOR_W    = 4,
  parameter int CHK_SHIFT  = 5,
  parameter int CW         = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] sw_red,
  input  logic [COLOR_W-1:0] sw_green,
  input  logic [COLOR_W-1:0] sw_blue,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic [CW-1:0]      x_pixel,
  output logic [CW-1:0]      y_pixel,
  output logic [COLOR_W-1:0] red_port,
  output logic [COLOR_W-1:0] green_port,
  output logic [COLOR_W-1:0] blue_port,
  output logic               pix_en,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BAR_MAX = CW'(BAR_W - 1);
  localparam logic          HS_ON   = (H_SYNC_POL != 0);
  localparam logic          VS_ON   = (V_SYNC_POL != 0);
`ifdef VGA_BORDER_EN
  localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE - 1);
`endif

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;
  logic [1:0]    r_mode;
  logic          r_adv;
  logic [CW-1:0] r_bar_pos;
  logic [2:0]    r_bar_idx;

  logic               w_stb;
  logic               w_h_wrap;
  logic [CW-1:0]      w_h_nxt;
  logic [CW-1:0]      w_v_nxt;
  logic               w_de;
  logic [COLOR_W-1:0] w_red;
  logic [COLOR_W-1:0] w_green;
  logic [COLOR_W-1:0] w_blue;

  assign w_stb    = (r_div == DIV_MAX);
  assign w_h_wrap = (r_h == H_MAX);
  assign w_h_nxt  = w_h_wrap ? '0 : r_h + 1'b1;
  assign w_v_nxt  = w_h_wrap ? ((r_v == V_MAX) ? '0 : r_v + 1'b1) : r_v;
  assign w_de     = (r_h < H_ACT) && (r_v < V_ACT);

  // r_adv marks the clk right after a counter step, so the output stage can tag that pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_h       <= '0;
      r_v       <= '0;
      r_mode    <= 2'd0;
      r_adv     <= 1'b0;
      r_bar_pos <= '0;
      r_bar_idx <= 3'd0;
    end else begin
      r_adv <= w_stb;
      r_div <= w_stb ? '0 : r_div + 1'b1;
      if (w_stb) begin
        r_h <= w_h_nxt;
        r_v <= w_v_nxt;
        if (w_h_nxt == '0 && w_v_nxt == '0)
          r_mode <= mode;
        if (w_h_nxt == '0) begin
          r_bar_pos <= '0;
          r_bar_idx <= 3'd0;
        end else if (r_bar_pos == BAR_MAX) begin
          r_bar_pos <= '0;
          if (r_bar_idx != 3'd7)
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
          r_bar_pos <= r_bar_pos + 1'b1;
        end
      end
    end
  end

  // Bar colours {R,G,B}: R = ~idx[1], G = ~idx[2], B = ~idx[0] reproduces 111,110,011,...,000.
  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    if (w_de) begin
      case (r_mode)
        2'd0: begin
          w_red   = sw_red;
          w_green = sw_green;
          w_blue  = sw_blue;
        end
        2'd1: begin
          w_red   = {COLOR_W{~r_bar_idx[1]}};
          w_green = {COLOR_W{~r_bar_idx[2]}};
          w_blue  = {COLOR_W{~r_bar_idx[0]}};
        end
        2'd2: begin
          if (r_h[CHK_SHIFT] ^ r_v[CHK_SHIFT]) begin
            w_red   = sw_red;
            w_green = sw_green;
            w_blue  = sw_blue;
          end
        end
        default: begin
          w_red   = COLOR_W'(r_h >> 6);
          w_green = COLOR_W'(r_v >> 6);
          w_blue  = sw_blue;
        end
      endcase
`ifdef VGA_BORDER_EN
      if (r_h == '0 || r_h == H_LAST || r_v == '0 || r_v == V_LAST) begin
        w_red   = '1;
        w_green = '1;
        w_blue  = '1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sync      <= ~HS_ON;
      v_sync      <= ~VS_ON;
      de          <= 1'b0;
      x_pixel     <= '0;
      y_pixel     <= '0;
      red_port    <= '0;
      green_port  <= '0;
      blue_port   <= '0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_sync      <= (r_h >= HS_BEG && r_h < HS_END) ? HS_ON : ~HS_ON;
      v_sync      <= (r_v >= VS_BEG && r_v < VS_END) ? VS_ON : ~VS_ON;
      de          <= w_de;
      x_pixel     <= w_de ? r_h : '0;
      y_pixel     <= w_de ? r_v : '0;
      red_port    <= w_red;
      green_port  <= w_green;
      blue_port   <= w_blue;
      pix_en      <= r_adv;
      line_start  <= r_adv && (r_h == '0);
      frame_start <= r_adv && (r_h == '0) && (r_v == '0);
    end
  end

endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
- Parametrised next-generation VGA timing generator with a built-in pattern source.
- Divides the system clock to a pixel-enable strobe and runs horizontal/vertical counters with programmable timing and sync polarity.
- Produces registered, mutually aligned sync, DE, pixel coordinates and RGB outputs.
- Generates one of four test patterns selected per frame. Sits between the board clock/switch inputs and the VGA connector pins.

Parameters:
- CLK_DIV, 4: clk cycles per pixel; must be >= 1 (1 = pixel strobe every clk).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_SYNC_POL, 0: asserted level of h_sync (0 = active-low).
- V_SYNC_POL, 0: asserted level of v_sync (0 = active-low).
- COLOR_W, 4: bits per colour channel.
- CHK_SHIFT, 5: checkerboard square size = 2^CHK_SHIFT pixels.
- CW, 10: coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient
- sw_red  in  COLOR_W  solid/checker red
- sw_green  in  COLOR_W  solid/checker green
- sw_blue  in  COLOR_W  solid/checker/gradient blue
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync
- de  out  1  display enable (active area)
- x_pixel  out  CW  active column; 0 when de=0
- y_pixel  out  CW  active row; 0 when de=0
- red_port  out  COLOR_W  red
- green_port  out  COLOR_W  green
- blue_port  out  COLOR_W  blue
- pix_en  out  1  one-clk strobe marking each pixel period
- line_start  out  1  one-clk pulse coinciding with the output update for h=0
- frame_start  out  1  one-clk pulse coinciding with the output update for h=0, v=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Divider: a counter runs 0..CLK_DIV-1. Internal strobe asserts for one clk when divider = CLK_DIV-1.
- Counters advance only on the internal strobe:
  - h wraps H_TOTAL-1 -> 0.
  - v increments when h wraps, and wraps V_TOTAL-1 -> 0.
- Sync region:
  - h_sync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - v_sync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - Asserted level = *_POL; deasserted level = ~*_POL.
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- All outputs are registered. Every output updates in the clk cycle after the counter update, so all outputs stay mutually aligned; latency counter->pins is exactly 1 clk.
- pix_en is the registered strobe, so it is aligned with the output update.
- Mode is sampled into an internal register only at the counter transition to h=0, v=0. Mode changes mid-frame take effect from the next frame.
- Patterns, evaluated only when de=1; RGB = 0 when de=0:
  - Solid: RGB = sw_red, sw_green, sw_blue.
  - Colour bars: bar index b = x / (H_ACTIVE/8), clamped to 7. Implement with a running bar counter reset at line start, not a divider.
    - Colour bits {R,G,B} for b = 0..7: 111, 110, 011, 010, 101, 100, 001, 000.
    - Each channel output is all-ones if its bit is 1, otherwise 0.
  - Checkerboard: if x[CHK_SHIFT] ^ y[CHK_SHIFT] = 1, RGB = switch colour; otherwise 0.
  - Gradient: red = x[COLOR_W+5:6]; green = y[COLOR_W+5:6]; blue = sw_blue. Zero-extend when CW < COLOR_W+6.
- Reset (asynchronous, immediate; also valid mid-frame):
  - Divider, h and v = 0; mode register = 0.
  - de, pix_en, line_start, frame_start, x_pixel, y_pixel and RGB = 0.
  - h_sync = ~H_SYNC_POL; v_sync = ~V_SYNC_POL.
- After rst deassertion, the first strobe occurs CLK_DIV clks later. It advances h to 1. frame_start does not fire until the first full wrap.
- CLK_DIV=1: strobe is high every clk; counters advance every clk.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: any active pixel with x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1 outputs all-ones RGB, overriding every mode.
- Undefined: no border logic; the pattern covers the full active area.

Test Plan:
- Reset, then defaults: h_sync low for exactly 96 pixel periods (384 clk). Line period 3200 clk; frame period 1,680,000 clk; v_sync low for 2 lines.
- Mode 0, sw = 4'hA/4'h5/4'hF: during de, RGB = A/5/F. While de=0, RGB = 0. x_pixel/y_pixel = 0 outside the active area.
- Mode 1: sample at x=0, 80, 160 and 639 -> RGB FFF, FF0, 0FF, 000.
- Mode 2, sw=F/F/F: (x=0,y=0) -> 000; (x=32,y=0) -> FFF; (x=32,y=32) -> 000.
- Switch mode 0->3 mid-frame: output stays solid until frame_start, then gradient; at x=64, y=128 -> red=1, green=2.
- CLK_DIV=1, H_SYNC_POL=1: h_sync is active-high for 96 clk. Assert rst mid-line: all outputs return to reset values within the same cycle. With VGA_BORDER_EN, pixel (0,5) = FFF in mode 0 with sw=0.
